// File: rtl/page_table_walker_if.sv
// Page-table-walker bus bundle: TLB miss requests, PTE memory read port,
// TLB fill/fault responses and status.
//   slave  : the walker's view (requests/mem data in, fills/faults/mem req out)
//   master : the environment's view (TLBs, memory, exception logic)
interface page_table_walker_if #(
  parameter int ADDR_W = 32,
  parameter int PTE_W  = 32
);
  logic [ADDR_W-1:0] ptbr;
  logic              itlb_req;
  logic [ADDR_W-1:0] itlb_va;
  logic              dtlb_req;
  logic [ADDR_W-1:0] dtlb_va;
  logic              dtlb_is_store;
  logic              user_mode;
  logic              kill;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [PTE_W-1:0]  mem_rdata;
  logic              itlb_done;
  logic              dtlb_done;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_va;
  logic [ADDR_W-1:0] fill_pa;
  logic              fill_writable;
  logic              fault_valid;
  logic [ADDR_W-1:0] fault_va;
  logic [1:0]        fault_cause;
  logic              busy;

  modport slave (
    input  ptbr, itlb_req, itlb_va, dtlb_req, dtlb_va, dtlb_is_store,
           user_mode, kill, mem_ack, mem_rdata,
    output mem_req, mem_addr, itlb_done, dtlb_done, fill_valid, fill_va,
           fill_pa, fill_writable, fault_valid, fault_va, fault_cause, busy
  );

  modport master (
    output ptbr, itlb_req, itlb_va, dtlb_req, dtlb_va, dtlb_is_store,
           user_mode, kill, mem_ack, mem_rdata,
    input  mem_req, mem_addr, itlb_done, dtlb_done, fill_valid, fill_va,
           fill_pa, fill_writable, fault_valid, fault_va, fault_cause, busy
  );
endinterface

// File: rtl/page_table_walker.sv
// Single-level hardware page table walker serving iTLB and dTLB misses.
// Reads one PTE per miss and answers with either a TLB fill or a page fault.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : page_table_walker_if.slave (requests, PTE read port, responses)
//
// state  | meaning
// IDLE   | no walk; accepts dTLB (priority) or iTLB miss
// REQ    | PTE read issued this cycle
// WAIT   | PTE read outstanding, waiting for mem_ack
// RESP   | one-cycle done + fill or fault pulse
// DRAIN  | walk killed while read outstanding; swallow the ack
module page_table_walker #(
  parameter int ADDR_W    = 32,
  parameter int PAGE_BITS = 12,
  parameter int PTE_W     = 32
) (
  input logic               clk_i,
  input logic               rst_ni,
  page_table_walker_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_DRAIN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] va_q;
  logic              store_q;
  logic              user_q;
  logic              sel_d_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              itlb_done_q;
  logic              dtlb_done_q;
  logic              fill_valid_q;
  logic [ADDR_W-1:0] fill_va_q;
  logic [ADDR_W-1:0] fill_pa_q;
  logic              fill_w_q;
  logic              fault_valid_q;
  logic [ADDR_W-1:0] fault_va_q;
  logic [1:0]        fault_cause_q;

  logic [ADDR_W-1:0] cap_va_d;
  logic [ADDR_W-1:0] pte_addr_d;
  logic              fault_d;
  logic [1:0]        cause_d;
  logic              unused_pte_bits;

  assign cap_va_d   = bus.dtlb_req ? bus.dtlb_va : bus.itlb_va;
  // PTE address wraps naturally at ADDR_W bits.
  assign pte_addr_d = bus.ptbr +
                      {{(PAGE_BITS-2){1'b0}}, cap_va_d[ADDR_W-1:PAGE_BITS], 2'b00};
  assign unused_pte_bits = ^bus.mem_rdata[PAGE_BITS-1:3];

  // Fault priority: not valid, then user on supervisor page, then store to RO.
  always_comb begin
    fault_d = 1'b1;
    cause_d = 2'd0;
    if (!bus.mem_rdata[0]) begin
      cause_d = 2'd0;
    end else if (user_q && !bus.mem_rdata[1]) begin
      cause_d = 2'd1;
    end else if (store_q && !bus.mem_rdata[2]) begin
      cause_d = 2'd2;
    end else begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      va_q          <= '0;
      store_q       <= 1'b0;
      user_q        <= 1'b0;
      sel_d_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      itlb_done_q   <= 1'b0;
      dtlb_done_q   <= 1'b0;
      fill_valid_q  <= 1'b0;
      fill_va_q     <= '0;
      fill_pa_q     <= '0;
      fill_w_q      <= 1'b0;
      fault_valid_q <= 1'b0;
      fault_va_q    <= '0;
      fault_cause_q <= 2'd0;
    end else begin
      itlb_done_q   <= 1'b0;
      dtlb_done_q   <= 1'b0;
      fill_valid_q  <= 1'b0;
      fault_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!bus.kill && (bus.dtlb_req || bus.itlb_req)) begin
            va_q       <= cap_va_d;
            store_q    <= bus.dtlb_req & bus.dtlb_is_store;
            user_q     <= bus.user_mode;
            sel_d_q    <= bus.dtlb_req;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pte_addr_d;
            state_q    <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          if (bus.kill) begin
            mem_req_q <= 1'b0;
            // A read already acked needs no draining.
            state_q   <= (state_q == S_REQ || bus.mem_ack) ? S_IDLE : S_DRAIN;
          end else if (bus.mem_ack) begin
            mem_req_q   <= 1'b0;
            itlb_done_q <= ~sel_d_q;
            dtlb_done_q <= sel_d_q;
            if (fault_d) begin
              fault_valid_q <= 1'b1;
              fault_va_q    <= va_q;
              fault_cause_q <= cause_d;
            end else begin
              fill_valid_q <= 1'b1;
              fill_va_q    <= {va_q[ADDR_W-1:PAGE_BITS], {PAGE_BITS{1'b0}}};
              fill_pa_q    <= {bus.mem_rdata[PTE_W-1:PAGE_BITS], {PAGE_BITS{1'b0}}};
              fill_w_q     <= bus.mem_rdata[2];
            end
            state_q <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        S_DRAIN: if (bus.mem_ack) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req       = mem_req_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.itlb_done     = itlb_done_q;
  assign bus.dtlb_done     = dtlb_done_q;
  assign bus.fill_valid    = fill_valid_q;
  assign bus.fill_va       = fill_va_q;
  assign bus.fill_pa       = fill_pa_q;
  assign bus.fill_writable = fill_w_q;
  assign bus.fault_valid   = fault_valid_q;
  assign bus.fault_va      = fault_va_q;
  assign bus.fault_cause   = fault_cause_q;
  assign bus.busy          = (state_q != S_IDLE);
endmodule

// File: doc/page_table_walker.md
Name: page_table_walker

Overview:
Hardware responder to iTLB/dTLB misses. It replaces the software map-and-IRET handler path for mapped pages. On a miss it reads one 32-bit PTE from a single-level page table in memory, then either returns a fill (VA page -> PA page) to the requesting TLB or reports a page fault to the exception logic. It sits beside the MEM-stage data port, arbitrates between the two TLBs, and uses a multi-cycle read-only memory port.

Parameters:
ADDR_W, 32, virtual/physical address width
PAGE_BITS, 12, page offset bits (4 KB pages)
PTE_W, 32, PTE width; PTE[31:12]=PPN, [2]=W writable, [1]=U user, [0]=V valid

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
ptbr  in  ADDR_W  page-table base PA, 4 KB aligned; sampled at walk start
itlb_req  in  1  iTLB miss request; held until itlb_done
itlb_va  in  ADDR_W  faulting fetch VA
dtlb_req  in  1  dTLB miss request; held until dtlb_done
dtlb_va  in  ADDR_W  faulting load/store VA
dtlb_is_store  in  1  dTLB miss came from a store
user_mode  in  1  requester is in user mode (vm_enable && !supervisor)
kill  in  1  pipeline flush; abandons the current walk
mem_req  out  1  PTE read request; held until mem_ack
mem_addr  out  ADDR_W  PTE address = ptbr + {VPN,2'b00}
mem_ack  in  1  one-cycle read completion
mem_rdata  in  PTE_W  PTE data, valid with mem_ack
itlb_done  out  1  one-cycle pulse: iTLB walk finished (fill or fault)
dtlb_done  out  1  one-cycle pulse: dTLB walk finished
fill_valid  out  1  one-cycle pulse: write {fill_va, fill_pa} into the TLB selected by the done pulse
fill_va  out  ADDR_W  VA page-aligned (low PAGE_BITS zero)
fill_pa  out  ADDR_W  {PPN, PAGE_BITS'b0}
fill_writable  out  1  PTE.W
fault_valid  out  1  one-cycle pulse: page fault
fault_va  out  ADDR_W  full faulting VA (feeds rm1)
fault_cause  out  2  0=not valid, 1=user access to supervisor page, 2=store to read-only
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0, including mem_addr, fill_*, fault_*. Captured VA, store flag and requester are cleared.
- States: IDLE, REQ, WAIT, RESP, DRAIN.
- IDLE: if dtlb_req, capture dtlb_va, dtlb_is_store, user_mode and sel=D, then go to REQ. Else if itlb_req, capture itlb_va with is_store=0 and sel=I, then go to REQ. dTLB has priority because its instruction is older. A capture and a kill in the same cycle: kill wins, stay IDLE.
- REQ: mem_req=1 and mem_addr=ptbr_cap + (va[31:12]<<2), computed mod 2^ADDR_W. Go to WAIT next cycle. mem_req stays asserted through WAIT until mem_ack.
- WAIT: on mem_ack, register mem_rdata and go to RESP. Latency is unbounded. An ack arriving in the REQ cycle is also accepted.
- RESP: exactly one cycle. Done pulse for sel only. Fault checks apply in order V==0, then user&&!U, then store&&!W. Fault: fault_valid=1, fault_va=captured VA, fault_cause set, fill_valid=0. Otherwise fill_valid=1 and fill_* set. Then go to IDLE. A new request is not accepted in the RESP cycle, so minimum spacing between walks is 1 idle cycle.
- kill in REQ: go to IDLE, mem_req dropped, no done.
- kill in WAIT: go to DRAIN. In DRAIN mem_req=0 (already issued); wait for mem_ack, discard the data, go to IDLE, no done/fill/fault.
- kill in RESP: ignored; the pulses still fire.
- Walk latency: request to done = 3 cycles + memory latency (mem_ack in the first WAIT cycle gives done 3 cycles after capture).
- A requester deasserting its req mid-walk is a protocol violation. The walk completes normally anyway.
- ptbr changes mid-walk do not affect the walk in progress.
- Reset mid-walk returns to IDLE immediately. The memory side must discard any outstanding ack.

Test Plan:
1. ptbr=0x4000, itlb_req VA=0x2000, user_mode=1, mem_ack after 2 cycles with rdata=0x00003003 -> mem_addr=0x4008; itlb_done+fill_valid with fill_va=0x2000, fill_pa=0x3000; dtlb_done=0.
2. dtlb_req VA=0x1804, is_store=1, rdata=0x00002007 -> mem_addr=0x4004; fill_pa=0x2000, fill_writable=1, dtlb_done.
3. Same store with rdata=0x00002003 -> fault_valid, cause=2, fault_va=0x1804, no fill. rdata=0x00002000 -> cause=0. Supervisor-page rdata=0x00002001 with user_mode=1 -> cause=1.
4. itlb_req and dtlb_req rise together -> dTLB walked first (dtlb_done); iTLB then walked with 1 idle cycle between, each getting its own done.
5. kill asserted in WAIT -> DRAIN, mem_req=0; a later mem_ack produces no done/fill; busy drops; the next request walks correctly.
6. reset pulled low during WAIT -> all outputs 0 asynchronously; after release, a fresh walk of VA=0x0 reads mem_addr=0x4000.
